inference_controller: RTL and testbench
=======================================

Name: inference_controller

Overview:
- Top-level sequencer for the MNIST datapath. Takes classify requests from the drawing/UI logic and issues a single-cycle Compute to the neural network. Waits for the network's Ready edge with a watchdog, then captures the 10 output probabilities.
- Scans the captured probabilities one per cycle to produce the predicted digit, its confidence and status flags for the display logic.
- Sits between the canvas/UI control and the network; it is the only driver of the network's Compute input.

Parameters:
- N_CLASSES, 10, number of output probabilities scanned (1..16).
- TIMEOUT_CYCLES, 65535, max cycles in WAIT before declaring an error (≥16).
- MIN_CONF, 16'h0400, confidence threshold for LowConf. Format is unsigned 16-bit, 1.0 = 16'h0800.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- Start  in  1  classify request pulse/level; sampled every cycle
- Clear  in  1  drops result, pending request and error
- NnReady  in  1  network Ready; probabilities are valid the cycle after its rising edge
- Prob  in  16 x N_CLASSES  network Probability outputs
- NnCompute  out  1  one-cycle launch pulse to network
- Busy  out  1  high in any state other than IDLE
- Done  out  1  one-cycle pulse when a result is written
- Valid  out  1  result registers hold a finished classification
- Digit  out  4  index of max probability
- Confidence  out  16  value of max probability
- LowConf  out  1  Confidence < MIN_CONF (valid with Valid)
- Error  out  1  sticky watchdog timeout flag

Behaviour:
- Reset (synchronous, active-high, Clk) values: state = IDLE; NnCompute, Busy, Done, Valid, LowConf, Error, pending = 0; Digit = 0; Confidence = 0; watchdog = 0.
- Reset mid-operation aborts immediately. No NnCompute is issued on the reset cycle or the cycle after.
- States:
  - IDLE: Start=1 → LAUNCH, and Error is cleared.
  - LAUNCH: NnCompute=1 for exactly this cycle; watchdog←0 → WAIT.
  - WAIT: increment watchdog.
    - Rising edge of NnReady (registered previous value, reset 0) → SETTLE.
    - Watchdog reaching TIMEOUT_CYCLES-1 without an edge → Error=1, Valid=0 → IDLE.
  - SETTLE: one cycle, absorbs the network's registered Probability update → SCAN.
  - SCAN: index i = 0..N_CLASSES-1, one per cycle.
    - Prob[0] is loaded as the running max.
    - For i>0, replace only if Prob[i] > max (unsigned, strict). Ties resolve to the lowest index.
    - After the last index → DONE.
  - DONE: Digit, Confidence, LowConf written; Valid=1; Done=1 for this cycle → IDLE.
- Latency: Start seen in IDLE at cycle 0 → NnCompute at cycle 1. NnReady edge at cycle R → Done at R+2+N_CLASSES (R+12 at default).
- Prob is sampled directly during SCAN, not snapshotted. The network holds it stable until the next Compute, and the controller issues none during SCAN.
- Start while Busy sets pending (single-deep; repeats collapse).
  - In DONE with pending=1: go to LAUNCH instead of IDLE and clear pending. The result is still published.
  - On timeout with pending=1: go to IDLE and clear pending. No auto-retry.
- Clear:
  - Valid←0 and Error←0, pending←0.
  - Clear while Busy does not abort the in-flight run, whose result is still published.
  - Clear and Start in the same cycle: Clear applies first, then Start is accepted.
- Valid stays 1 until Clear, Reset, a timeout, or the next DONE overwrites it. Digit/Confidence hold their last values otherwise.
- NnReady already high at LAUNCH does not count; only a 0→1 transition during WAIT completes the wait.

Test Plan:
- Reset, Start pulse, NnReady rises 40 cycles after NnCompute; Prob = {0x0100 ×10} except Prob[7] = 0x07F0 → single NnCompute pulse, Done at edge+12, Digit=7, Confidence=0x07F0, LowConf=0, Valid=1.
- Prob[2]=Prob[5]=0x0600, others 0x0010 → Digit=2 (lowest index wins on tie).
- All Prob = 0x0300 → Digit=0, Confidence=0x0300, LowConf=1.
- NnReady never rises, TIMEOUT_CYCLES=100 → Error=1 exactly 100 cycles after LAUNCH, Valid=0, Busy=0. Next Start clears Error and relaunches.
- Start pulsed three times during WAIT → first result published, then exactly one extra NnCompute the cycle after DONE, then IDLE.
- Reset asserted in SCAN at i=4 → all outputs at reset values next cycle, no Done, no NnCompute. Clear with Valid=1 → Valid=0, Digit unchanged.

Source files
------------

// File: rtl/inference_controller.sv
// Classify sequencer for the MNIST datapath: launches the network, waits for its
// Ready edge under a watchdog, then scans the probabilities for the arg-max digit.
module inference_controller #(
  parameter int unsigned N_CLASSES      = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [15:0] MIN_CONF       = 16'h0400
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Clear,
  input  logic                    NnReady,
  input  logic [16*N_CLASSES-1:0] Prob,
  output logic                    NnCompute,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Valid,
  output logic [3:0]              Digit,
  output logic [15:0]             Confidence,
  output logic                    LowConf,
  output logic                    Error
);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StSettle,
    StScan,
    StDone
  } state_e;

  // Watchdog "reaches" TIMEOUT_CYCLES-1 on the WAIT cycle whose increment lands there.
  localparam logic [31:0] WdLast  = 32'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]  IdxLast = 4'(N_CLASSES - 1);

  state_e      state_q, state_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] max_q, max_d;
  logic [3:0]  arg_q, arg_d;
  logic        ready_q;
  logic        pending_q, pending_d;
  logic        valid_d, error_d, low_d;
  logic [3:0]  digit_d;
  logic [15:0] conf_d;
  logic [15:0] prob_sel;
  logic        ready_rise;

  assign ready_rise = NnReady & ~ready_q;

  // Prob is read live during SCAN; the network holds it until the next Compute.
  always_comb begin
    prob_sel = '0;
    for (int unsigned i = 0; i < N_CLASSES; i++) begin
      if (idx_q == 4'(i)) prob_sel = Prob[16*i +: 16];
    end
  end

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    idx_d     = idx_q;
    max_d     = max_q;
    arg_d     = arg_q;
    pending_d = pending_q;
    valid_d   = Valid;
    error_d   = Error;
    digit_d   = Digit;
    conf_d    = Confidence;
    low_d     = LowConf;

    // Clear takes effect before a same-cycle Start is considered.
    if (Clear) begin
      valid_d   = 1'b0;
      error_d   = 1'b0;
      pending_d = 1'b0;
    end
    if (state_q != StIdle && Start) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          error_d = 1'b0;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        wd_d = wd_q + 32'd1;
        if (ready_rise) begin
          state_d = StSettle;
        end else if (wd_q == WdLast) begin
          error_d   = 1'b1;
          valid_d   = 1'b0;
          pending_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StSettle: begin
        idx_d   = '0;
        state_d = StScan;
      end
      StScan: begin
        // Strict compare keeps the lowest index on ties.
        if (idx_q == 4'd0 || prob_sel > max_q) begin
          max_d = prob_sel;
          arg_d = idx_q;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == IdxLast) begin
          digit_d = arg_d;
          conf_d  = max_d;
          low_d   = (max_d < MIN_CONF);
          valid_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (pending_d) begin
          pending_d = 1'b0;
          state_d   = StLaunch;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      wd_q       <= '0;
      idx_q      <= '0;
      max_q      <= '0;
      arg_q      <= '0;
      ready_q    <= 1'b0;
      pending_q  <= 1'b0;
      Valid      <= 1'b0;
      Error      <= 1'b0;
      Digit      <= '0;
      Confidence <= '0;
      LowConf    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      idx_q      <= idx_d;
      max_q      <= max_d;
      arg_q      <= arg_d;
      ready_q    <= NnReady;
      pending_q  <= pending_d;
      Valid      <= valid_d;
      Error      <= error_d;
      Digit      <= digit_d;
      Confidence <= conf_d;
      LowConf    <= low_d;
    end
  end

  // Masked during Reset so an abort from LAUNCH never leaks a launch pulse.
  assign NnCompute = (state_q == StLaunch) & ~Reset;
  assign Busy      = (state_q != StIdle);
  assign Done      = (state_q == StDone);

endmodule

// File: tb/tb_inference_controller.sv
// Directed bench for inference_controller: table of arg-max vectors plus
// hand-written timeout, pending-request and reset-abort sequences.
module tb_inference_controller;

  localparam int N  = 10;
  localparam int PW = 16 * N;

  logic          Clk = 1'b0;
  logic          Reset, Start, Clear, NnReady;
  logic [PW-1:0] Prob;
  logic          NnCompute, Busy, Done, Valid, LowConf, Error;
  logic [3:0]    Digit;
  logic [15:0]   Confidence;

  inference_controller #(
    .N_CLASSES      (N),
    .TIMEOUT_CYCLES (100),
    .MIN_CONF       (16'h0400)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Clear      (Clear),
    .NnReady    (NnReady),
    .Prob       (Prob),
    .NnCompute  (NnCompute),
    .Busy       (Busy),
    .Done       (Done),
    .Valid      (Valid),
    .Digit      (Digit),
    .Confidence (Confidence),
    .LowConf    (LowConf),
    .Error      (Error)
  );

  always #5 Clk = ~Clk;

  int cyc   = 0;
  int ncomp = 0;
  int ndone = 0;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (NnCompute) ncomp <= ncomp + 1;
    if (Done) ndone <= ndone + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [PW-1:0] fill(input logic [15:0] v);
    logic [PW-1:0] p;
    for (int i = 0; i < N; i++) p[16*i +: 16] = v;
    return p;
  endfunction

  function automatic logic [PW-1:0] put(input logic [PW-1:0] p, input int i,
                                        input logic [15:0] v);
    logic [PW-1:0] r;
    r = p;
    r[16*i +: 16] = v;
    return r;
  endfunction

  typedef struct {
    logic [PW-1:0] prob;
    logic [3:0]    digit;
    logic [15:0]   conf;
    logic          low;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_done(input string name);
    for (int k = 0; k < 60 && Done !== 1'b1; k++) step();
    chk({name, "_done_seen"}, 32'(Done), 32'd1);
  endtask

  // Full classify: Start pulse, Ready rises `delay` cycles after the launch cycle.
  task automatic classify(input logic [PW-1:0] p, input int delay, input bit clr,
                          input logic [3:0] ed, input logic [15:0] ec, input logic el);
    int c0, r;
    Prob  = p;
    c0    = ncomp;
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("launch_pulse", 32'(NnCompute), 32'd1);
    chk("launch_err_clr", 32'(Error), 32'd0);
    for (int k = 0; k < delay; k++) begin
      Clear = (clr && k == 2);
      step();
    end
    Clear = 1'b0;
    chk("busy_wait", 32'(Busy), 32'd1);
    NnReady = 1'b1;
    r = cyc;
    step();
    wait_done("run");
    chk("done_latency", 32'(cyc - r), 32'd12);
    chk("digit", 32'(Digit), 32'(ed));
    chk("confidence", 32'(Confidence), 32'(ec));
    chk("lowconf", 32'(LowConf), 32'(el));
    chk("valid", 32'(Valid), 32'd1);
    chk("one_compute", 32'(ncomp - c0), 32'd1);
    step();
    NnReady = 1'b0;
    chk("idle_after", 32'(Busy), 32'd0);
    chk("done_pulse", 32'(Done), 32'd0);
  endtask

  initial begin
    int l, r, c0, nd0;
    logic [PW-1:0] p;

    p = put(fill(16'h0100), 7, 16'h07F0);
    vecs[0] = '{p, 4'd7, 16'h07F0, 1'b0};
    p = put(put(fill(16'h0010), 2, 16'h0600), 5, 16'h0600);
    vecs[1] = '{p, 4'd2, 16'h0600, 1'b0};
    vecs[2] = '{fill(16'h0300), 4'd0, 16'h0300, 1'b1};
    p = put(fill(16'h03FF), 9, 16'h0400);
    vecs[3] = '{p, 4'd9, 16'h0400, 1'b0};
    p = put(fill(16'hFFFE), 0, 16'hFFFF);
    vecs[4] = '{p, 4'd0, 16'hFFFF, 1'b0};
    for (int i = 0; i < N; i++) p[16*i +: 16] = 16'(i * 16'h0100);
    vecs[5] = '{p, 4'd9, 16'h0900, 1'b0};

    Reset = 1'b1; Start = 1'b0; Clear = 1'b0; NnReady = 1'b0; Prob = '0;
    step();
    step();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_compute", 32'(NnCompute), 32'd0);
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_digit", 32'(Digit), 32'd0);
    chk("rst_conf", 32'(Confidence), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    Reset = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      classify(vecs[v].prob, (v == 0) ? 40 : 5 + v, v == 3,
               vecs[v].digit, vecs[v].conf, vecs[v].low);
    end

    // Watchdog: Ready never rises.
    Start = 1'b1;
    step();
    Start = 1'b0;
    l = cyc;
    chk("to_launch", 32'(NnCompute), 32'd1);
    for (int k = 0; k < 150 && Error !== 1'b1; k++) step();
    chk("to_error", 32'(Error), 32'd1);
    chk("to_latency", 32'(cyc - l), 32'd100);
    chk("to_valid", 32'(Valid), 32'd0);
    chk("to_busy", 32'(Busy), 32'd0);
    step();
    step();
    chk("to_sticky", 32'(Error), 32'd1);
    classify(vecs[0].prob, 8, 1'b0, vecs[0].digit, vecs[0].conf, vecs[0].low);

    // Clear with a valid result keeps Digit.
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    chk("clr_valid", 32'(Valid), 32'd0);
    chk("clr_digit", 32'(Digit), 32'd7);
    chk("clr_conf", 32'(Confidence), 32'h07F0);

    // Repeated Start during WAIT collapses to one extra launch.
    Prob = vecs[1].prob;
    c0 = ncomp;
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Start = 1'b1; step();
      Start = 1'b0; step();
    end
    NnReady = 1'b1;
    r = cyc;
    step();
    wait_done("pend1");
    chk("pend_latency", 32'(cyc - r), 32'd12);
    chk("pend_digit", 32'(Digit), 32'd2);
    step();
    chk("pend_relaunch", 32'(NnCompute), 32'd1);
    step();
    NnReady = 1'b0;
    step(); step(); step();
    chk("pend_no_stale_ready", 32'(Busy), 32'd1);
    NnReady = 1'b1;
    r = cyc;
    step();
    wait_done("pend2");
    chk("pend2_latency", 32'(cyc - r), 32'd12);
    step();
    NnReady = 1'b0;
    step();
    step();
    chk("pend_idle", 32'(Busy), 32'd0);
    chk("pend_two_computes", 32'(ncomp - c0), 32'd2);

    // Reset in SCAN at i=4 aborts with no Done and no launch.
    Prob = vecs[0].prob;
    Start = 1'b1;
    step();
    Start = 1'b0;
    step(); step();
    NnReady = 1'b1;
    r = cyc;
    for (int k = 0; k < 6; k++) step();
    chk("scan_busy", 32'(Busy), 32'd1);
    nd0 = ndone;
    c0 = ncomp;
    Reset = 1'b1;
    Start = 1'b1;
    step();
    Reset = 1'b0;
    Start = 1'b0;
    NnReady = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_valid", 32'(Valid), 32'd0);
    chk("abort_digit", 32'(Digit), 32'd0);
    chk("abort_conf", 32'(Confidence), 32'd0);
    chk("abort_low", 32'(LowConf), 32'd0);
    chk("abort_error", 32'(Error), 32'd0);
    chk("abort_compute", 32'(NnCompute), 32'd0);
    step();
    chk("abort_compute_next", 32'(NnCompute), 32'd0);
    step();
    chk("abort_no_done", 32'(ndone - nd0), 32'd0);
    chk("abort_no_launch", 32'(ncomp - c0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
